// File: rtl/vga_pkg.sv
// Shared timing constants and helpers for the VGA raster generator.
// Default set is 800x600@72 Hz from a 50 MHz pixel clock.
package vga_pkg;

  localparam int COORD_W = 11;

  localparam int   DEF_H_ACTIVE = 800;
  localparam int   DEF_H_FP     = 56;
  localparam int   DEF_H_SYNC   = 120;
  localparam int   DEF_H_BP     = 64;
  localparam int   DEF_V_ACTIVE = 600;
  localparam int   DEF_V_FP     = 37;
  localparam int   DEF_V_SYNC   = 6;
  localparam int   DEF_V_BP     = 23;
  localparam logic DEF_H_POL    = 1'b1;
  localparam logic DEF_V_POL    = 1'b1;

  // One decoded raster sample; the output register holds exactly this.
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               active;
    logic               hsync;
    logic               vsync;
    logic               sof;
    logic               eof;
  } raster_t;

  function automatic int axis_total(int act, int fp, int sync, int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int sync_start(int act, int fp);
    return act + fp;
  endfunction

  function automatic int sync_end(int act, int fp, int sync);
    return act + fp + sync - 1;
  endfunction

endpackage

// File: rtl/vga_timing_gen_raster_axis_cnt.sv
// Modulo-MOD counter for one raster axis. wrap is combinational and only
// fires on an enabled cycle at the terminal count, so it can directly
// enable the next axis.
module raster_axis_cnt
  import vga_pkg::*;
#(
  parameter int MOD = 1040
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  output logic [COORD_W-1:0] cnt,
  output logic               wrap
);

  localparam logic [COORD_W-1:0] LAST = COORD_W'(MOD - 1);

  assign wrap = en && (cnt == LAST);

  // Advance on enable, returning to zero after the terminal count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  cnt <= '0;
    else if (en)   cnt <= wrap ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: two cascaded axis counters, a decode of the
// current position, and a single output register so every output lines up.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic H_POL    = DEF_H_POL,
  parameter logic V_POL    = DEF_V_POL
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                pix_en,
  output logic [COORD_W-1:0]  x,
  output logic [COORD_W-1:0]  y,
  output logic                active,
  output logic                hsync,
  output logic                vsync,
  output logic                sof,
  output logic                eof,
  output logic [15:0]         frame_cnt
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [COORD_W-1:0] HA_C  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] VA_C  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS0_C = COORD_W'(sync_start(H_ACTIVE, H_FP));
  localparam logic [COORD_W-1:0] HS1_C = COORD_W'(sync_end(H_ACTIVE, H_FP, H_SYNC));
  localparam logic [COORD_W-1:0] VS0_C = COORD_W'(sync_start(V_ACTIVE, V_FP));
  localparam logic [COORD_W-1:0] VS1_C = COORD_W'(sync_end(V_ACTIVE, V_FP, V_SYNC));
  localparam logic [COORD_W-1:0] HL_C  = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] VL_C  = COORD_W'(V_ACTIVE - 1);

  // Counters are COORD_W bits wide; larger rasters cannot be represented.
  if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_bad_totals
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed counter range");
  end

  logic [COORD_W-1:0] hcnt, vcnt;
  logic               h_wrap;
  logic               v_wrap_unused;
  raster_t            nxt, out_q;

  raster_axis_cnt #(.MOD(H_TOTAL)) u_hcnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (pix_en),
    .cnt     (hcnt),
    .wrap    (h_wrap)
  );

  raster_axis_cnt #(.MOD(V_TOTAL)) u_vcnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (pix_en && h_wrap),
    .cnt     (vcnt),
    .wrap    (v_wrap_unused)
  );

  // Decode the current counter position into the next output sample.
  always_comb begin
    nxt        = '0;
    nxt.x      = hcnt;
    nxt.y      = vcnt;
    nxt.active = (hcnt < HA_C) && (vcnt < VA_C);
    nxt.hsync  = (hcnt >= HS0_C && hcnt <= HS1_C) ? H_POL : ~H_POL;
    nxt.vsync  = (vcnt >= VS0_C && vcnt <= VS1_C) ? V_POL : ~V_POL;
    nxt.sof    = (hcnt == '0) && (vcnt == '0);
    nxt.eof    = (hcnt == HL_C) && (vcnt == VL_C);
  end

  // Output register: load on enabled cycles; on stalls hold the raster but
  // drop the frame pulses so they never stretch. frame_cnt steps together
  // with the eof it accompanies.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q       <= '0;
      out_q.hsync <= ~H_POL;
      out_q.vsync <= ~V_POL;
      frame_cnt   <= '0;
    end else if (pix_en) begin
      out_q <= nxt;
      if (nxt.eof) frame_cnt <= frame_cnt + 16'd1;
    end else begin
      out_q.sof <= 1'b0;
      out_q.eof <= 1'b0;
    end
  end

  assign x      = out_q.x;
  assign y      = out_q.y;
  assign active = out_q.active;
  assign hsync  = out_q.hsync;
  assign vsync  = out_q.vsync;
  assign sof    = out_q.sof;
  assign eof    = out_q.eof;

endmodule
